// File: rtl/button_pulse_gen.sv
// button_pulse_gen: per-button two-flop synchronizer, debounce counter and press/release FSM
// producing registered one-cycle pushed/released strobes and a debounced held level.
module button_pulse_gen #(
   parameter int NUM_BTN         = 5,
   parameter int DEBOUNCE_CYCLES = 120000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] pushed,
   output logic [NUM_BTN-1:0] released,
   output logic [NUM_BTN-1:0] held
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] DB = CNT_W'(DEBOUNCE_CYCLES);
   typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
   logic [NUM_BTN-1:0] sync1, sync2, push_n, rel_n, held_n;
   state_t state [NUM_BTN];
   state_t state_n [NUM_BTN];
   logic [CNT_W-1:0] cnt [NUM_BTN];
   logic [CNT_W-1:0] cnt_n [NUM_BTN];
   logic [CNT_W-1:0] cnt_inc;
   logic hi, move, done;
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
      end
   end
   // RELEASED/PRESSED hold cnt at 0, so the first differing sample counts as cnt=1,
   // which also covers the single-cycle debounce shortcut.
   always_comb begin
      push_n  = '0;
      rel_n   = '0;
      held_n  = '0;
      hi      = 1'b0;
      move    = 1'b0;
      done    = 1'b0;
      cnt_inc = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         hi         = state[i] == PRESSED || state[i] == RELEASE_WAIT;
         move       = hi ^ sync2[i];
         cnt_inc    = cnt[i] + 1'b1;
         done       = move && cnt_inc == DB;
         state_n[i] = !move ? (hi ? PRESSED : RELEASED) :
                      done  ? (hi ? RELEASED : PRESSED) :
                              (hi ? RELEASE_WAIT : PRESS_WAIT);
         cnt_n[i]   = (move && !done) ? cnt_inc : '0;
         push_n[i]  = done && !hi;
         rel_n[i]   = done && hi;
         held_n[i]  = state_n[i] == PRESSED || state_n[i] == RELEASE_WAIT;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BTN; i++) begin
            state[i] <= RELEASED;
            cnt[i]   <= '0;
         end
         pushed   <= '0;
         released <= '0;
         held     <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         pushed   <= push_n;
         released <= rel_n;
         held     <= held_n;
      end
   end
endmodule

// File: tb/tb_button_pulse_gen.sv
// tb_button_pulse_gen: directed and random stimulus for two instances (debounce 4 and 1)
// checked against a run-length debounce reference model.
module tb_button_pulse_gen;
   localparam int N = 5;
   logic tb_clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] btn_raw = '0;
   logic [N-1:0] pushed, released, held, pushed1, released1, held1;
   logic [N-1:0] exp_p [2];
   logic [N-1:0] exp_r [2];
   logic [N-1:0] exp_h [2];
   int n_chk = 0;
   int n_fail = 0;

   always #5 tb_clk = ~tb_clk;

   button_pulse_gen #(.NUM_BTN(N), .DEBOUNCE_CYCLES(4)) dut (
      .clk(tb_clk), .rst(rst), .btn_raw(btn_raw),
      .pushed(pushed), .released(released), .held(held)
   );
   button_pulse_gen #(.NUM_BTN(N), .DEBOUNCE_CYCLES(1)) dut1 (
      .clk(tb_clk), .rst(rst), .btn_raw(btn_raw),
      .pushed(pushed1), .released(released1), .held(held1)
   );

   // Debounced level flips once a run of samples that disagree with it reaches the debounce length.
   always @(posedge tb_clk) begin : model
      logic [N-1:0] s1, s2, s;
      logic [N-1:0] lvl [2];
      logic [N-1:0] push [2];
      logic [N-1:0] rel [2];
      int run [2][N];
      s  = s2;
      s2 = s1;
      s1 = btn_raw;
      for (int k = 0; k < 2; k++) begin
         push[k] = '0;
         rel[k]  = '0;
         for (int i = 0; i < N; i++) begin
            if (rst) begin
               lvl[k][i] = 1'b0;
               run[k][i] = 0;
            end else if (s[i] !== lvl[k][i]) begin
               run[k][i]++;
               if (run[k][i] == (k == 0 ? 4 : 1)) begin
                  lvl[k][i] = s[i];
                  run[k][i] = 0;
                  if (s[i]) push[k][i] = 1'b1;
                  else rel[k][i] = 1'b1;
               end
            end else begin
               run[k][i] = 0;
            end
         end
      end
      if (rst) begin
         s1 = '0;
         s2 = '0;
      end
      exp_p <= push;
      exp_r <= rel;
      exp_h <= lvl;
   end

   task automatic drive(input logic [N-1:0] b, input logic r);
      @(negedge tb_clk);
      btn_raw = b;
      rst = r;
   endtask

   task automatic test_reset;
      for (int c = 0; c < 3; c++) begin
         drive('1, c == 2 ? 1'b0 : 1'b1);
         n_chk++;
         if ({pushed, released, held, pushed1, released1, held1} !== '0) begin
            n_fail++;
            $display("FAIL reset_clear: got p/r/h=%b/%b/%b p1/r1/h1=%b/%b/%b want all 0",
                     pushed, released, held, pushed1, released1, held1);
         end
      end
      for (int e = 1; e <= 8; e++) begin
         drive('1, 1'b0);
         n_chk++;
         if (pushed !== {N{e == 6}}) begin
            n_fail++;
            $display("FAIL reset_release_push edge %0d: got %b want %b", e, pushed, {N{e == 6}});
         end
         n_chk++;
         if (pushed1 !== {N{e == 3}}) begin
            n_fail++;
            $display("FAIL reset_release_push1 edge %0d: got %b want %b", e, pushed1, {N{e == 3}});
         end
      end
      for (int c = 0; c < 12; c++) begin
         drive('0, 1'b0);
         n_chk++;
         if ({pushed, released, held} !== {exp_p[0], exp_r[0], exp_h[0]}) begin
            n_fail++;
            $display("FAIL model4 @%0t: p/r/h=%b/%b/%b want %b/%b/%b", $time,
                     pushed, released, held, exp_p[0], exp_r[0], exp_h[0]);
         end
         n_chk++;
         if ({pushed1, released1, held1} !== {exp_p[1], exp_r[1], exp_h[1]}) begin
            n_fail++;
            $display("FAIL model1 @%0t: p/r/h=%b/%b/%b want %b/%b/%b", $time,
                     pushed1, released1, held1, exp_p[1], exp_r[1], exp_h[1]);
         end
      end
   endtask

   task automatic test_clean_press;
      drive(5'b01000, 1'b0);
      for (int e = 1; e <= 19; e++) begin
         drive(5'b01000, 1'b0);
         n_chk++;
         if (pushed !== (e == 6 ? 5'b01000 : 5'b00000) || held !== (e >= 6 ? 5'b01000 : 5'b00000)) begin
            n_fail++;
            $display("FAIL clean_press edge %0d: got pushed=%b held=%b", e, pushed, held);
         end
      end
      drive(5'b00000, 1'b0);
      for (int f = 1; f <= 10; f++) begin
         drive(5'b00000, 1'b0);
         n_chk++;
         if (released !== (f == 6 ? 5'b01000 : 5'b00000) || held !== (f < 6 ? 5'b01000 : 5'b00000)
             || pushed !== 5'b00000) begin
            n_fail++;
            $display("FAIL clean_release edge %0d: got released=%b held=%b pushed=%b", f, released, held, pushed);
         end
         n_chk++;
         if ({pushed1, released1, held1} !== {exp_p[1], exp_r[1], exp_h[1]}) begin
            n_fail++;
            $display("FAIL model1 @%0t: p/r/h=%b/%b/%b want %b/%b/%b", $time,
                     pushed1, released1, held1, exp_p[1], exp_r[1], exp_h[1]);
         end
      end
   endtask

   task automatic test_bounce;
      logic [8:0] pat;
      logic [N-1:0] b;
      int np;
      pat = 9'b011101101;
      for (int j = 0; j < 19; j++) begin
         b = '0;
         b[4] = j < 9 ? pat[j] : 1'b0;
         drive(b, 1'b0);
         n_chk++;
         if (pushed[4] !== 1'b0 || held[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_reject step %0d: got pushed4=%b held4=%b want 0/0", j, pushed[4], held[4]);
         end
         n_chk++;
         if ({pushed1, released1, held1} !== {exp_p[1], exp_r[1], exp_h[1]}) begin
            n_fail++;
            $display("FAIL model1 @%0t: p/r/h=%b/%b/%b want %b/%b/%b", $time,
                     pushed1, released1, held1, exp_p[1], exp_r[1], exp_h[1]);
         end
      end
      np = 0;
      for (int j = 0; j < 10; j++) begin
         drive(5'b10000, 1'b0);
         np += int'(pushed[4]);
      end
      n_chk++;
      if (np != 1) begin
         n_fail++;
         $display("FAIL bounce_steady_push: got %0d pulses want 1", np);
      end
      for (int j = 0; j < 10; j++) begin
         drive(5'b00000, 1'b0);
         n_chk++;
         if ({pushed, released, held} !== {exp_p[0], exp_r[0], exp_h[0]}) begin
            n_fail++;
            $display("FAIL model4 @%0t: p/r/h=%b/%b/%b want %b/%b/%b", $time,
                     pushed, released, held, exp_p[0], exp_r[0], exp_h[0]);
         end
      end
   endtask

   task automatic test_release_bounce;
      int np;
      np = 0;
      for (int j = 0; j < 10; j++) begin
         drive(5'b01000, 1'b0);
         np += int'(pushed[3]);
      end
      n_chk++;
      if (held[3] !== 1'b1) begin
         n_fail++;
         $display("FAIL release_bounce_held: got %b want 1", held[3]);
      end
      for (int j = 0; j < 15; j++) begin
         drive(j < 3 ? 5'b00000 : 5'b01000, 1'b0);
         np += int'(pushed[3]);
         n_chk++;
         if (released[3] !== 1'b0 || held[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL release_bounce step %0d: got released3=%b held3=%b want 0/1", j, released[3], held[3]);
         end
      end
      n_chk++;
      if (np != 1) begin
         n_fail++;
         $display("FAIL release_bounce_push_count: got %0d want 1", np);
      end
      for (int j = 0; j < 10; j++) begin
         drive(5'b00000, 1'b0);
         n_chk++;
         if ({pushed, released, held} !== {exp_p[0], exp_r[0], exp_h[0]}) begin
            n_fail++;
            $display("FAIL model4 @%0t: p/r/h=%b/%b/%b want %b/%b/%b", $time,
                     pushed, released, held, exp_p[0], exp_r[0], exp_h[0]);
         end
      end
   endtask

   task automatic test_concurrent;
      int n3, n4;
      n3 = 0;
      n4 = 0;
      for (int j = 0; j < 50; j++) begin
         drive(5'b11000, 1'b0);
         n3 += int'(pushed[3]);
         n4 += int'(pushed[4]);
         n_chk++;
         if (pushed[3] !== pushed[4]) begin
            n_fail++;
            $display("FAIL concurrent_same_cycle step %0d: got pushed3=%b pushed4=%b", j, pushed[3], pushed[4]);
         end
      end
      n_chk++;
      if (n3 != 1 || n4 != 1) begin
         n_fail++;
         $display("FAIL concurrent_count: got %0d/%0d pulses want 1/1", n3, n4);
      end
      for (int j = 0; j < 10; j++) begin
         drive(5'b00000, 1'b0);
         n_chk++;
         if ({pushed, released, held} !== {exp_p[0], exp_r[0], exp_h[0]}) begin
            n_fail++;
            $display("FAIL model4 @%0t: p/r/h=%b/%b/%b want %b/%b/%b", $time,
                     pushed, released, held, exp_p[0], exp_r[0], exp_h[0]);
         end
      end
   endtask

   task automatic test_mid_reset;
      drive(5'b00001, 1'b0);
      for (int e = 1; e <= 3; e++) begin
         drive(5'b00001, 1'b0);
         n_chk++;
         if (pushed[0] !== 1'b0 || pushed1[0] !== (e == 3)) begin
            n_fail++;
            $display("FAIL mid_reset_pre edge %0d: got pushed0=%b pushed1_0=%b", e, pushed[0], pushed1[0]);
         end
      end
      drive(5'b00001, 1'b1);
      drive(5'b00001, 1'b0);
      n_chk++;
      if ({pushed, released, held, pushed1, released1, held1} !== '0) begin
         n_fail++;
         $display("FAIL mid_reset_clear: got p/r/h=%b/%b/%b p1/r1/h1=%b/%b/%b want all 0",
                  pushed, released, held, pushed1, released1, held1);
      end
      for (int e = 1; e <= 8; e++) begin
         drive(5'b00001, 1'b0);
         n_chk++;
         if (pushed !== {4'b0, e == 6} || pushed1 !== {4'b0, e == 3} || released !== '0 || released1 !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_reaccept edge %0d: got pushed=%b pushed1=%b released=%b released1=%b",
                     e, pushed, pushed1, released, released1);
         end
      end
      for (int j = 0; j < 10; j++) drive(5'b00000, 1'b0);
   endtask

   task automatic test_random;
      logic [N-1:0] b;
      logic r;
      b = '0;
      for (int j = 0; j < 3000; j++) begin
         for (int i = 0; i < N; i++) if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
         r = $urandom_range(0, 255) == 0;
         drive(b, r);
         n_chk++;
         if ({pushed, released, held} !== {exp_p[0], exp_r[0], exp_h[0]}) begin
            n_fail++;
            $display("FAIL model4 @%0t: p/r/h=%b/%b/%b want %b/%b/%b", $time,
                     pushed, released, held, exp_p[0], exp_r[0], exp_h[0]);
         end
         n_chk++;
         if ({pushed1, released1, held1} !== {exp_p[1], exp_r[1], exp_h[1]}) begin
            n_fail++;
            $display("FAIL model1 @%0t: p/r/h=%b/%b/%b want %b/%b/%b", $time,
                     pushed1, released1, held1, exp_p[1], exp_r[1], exp_h[1]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_clean_press;
      test_bounce;
      test_release_bounce;
      test_concurrent;
      test_mid_reset;
      test_random;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/button_pulse_gen.md
Name: button_pulse_gen

Overview:
- Front-end conditioner for the player push-buttons. Turns each raw, asynchronous, bouncy button level into a clean single-cycle press pulse, a release pulse and a debounced held level.
- Sits between the board pins and every consumer of `pushed_*` strobes: the mode state machine (buttons 3 and 4) and the fret/note logic (buttons 0–2).
- Each button has its own synchronizer, debounce counter and four-state FSM. Buttons are fully independent.

Parameters:
- NUM_BTN, 5, number of independent button channels.
- DEBOUNCE_CYCLES, 120000, consecutive stable synchronized samples required to accept a press or release. The default is 10 ms at 12 MHz. Legal range is 1 to 2^20.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), derived localparam giving the counter width. It must not be overridden.

Ports:
- clk  in  1  system clock, 12 MHz; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  NUM_BTN  raw button levels, asynchronous, 1 = pressed.
- pushed  out  NUM_BTN  one-cycle pulse per accepted press; bit i drives the consumer's pushed_i.
- released  out  NUM_BTN  one-cycle pulse per accepted release.
- held  out  NUM_BTN  debounced level; 1 while in PRESSED or RELEASE_WAIT.

Behaviour:
- Reset:
  - Synchronous, active-high. While rst=1 at a rising edge, the following are cleared: sync flops, counters, FSM = RELEASED, and pushed, released and held = 0.
  - Reset has priority over all other activity.
- Synchronizer: two flops per bit, sync1 then sync2. The FSM sees only sync2.
- FSM states per channel: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
- RELEASED:
  - sync2=1 → PRESS_WAIT with cnt=1.
  - If DEBOUNCE_CYCLES=1, go directly to PRESSED with pushed=1.
- PRESS_WAIT:
  - sync2=1 → cnt+1.
  - When cnt+1 == DEBOUNCE_CYCLES → PRESSED, pushed=1 for that one cycle, cnt=0.
  - sync2=0 → RELEASED, cnt=0. There is no pulse (bounce rejected).
- PRESSED:
  - held=1.
  - sync2=0 → RELEASE_WAIT with cnt=1, with the same DEBOUNCE_CYCLES=1 shortcut.
- RELEASE_WAIT:
  - held stays 1.
  - sync2=0 → cnt+1.
  - When cnt+1 == DEBOUNCE_CYCLES → RELEASED, released=1 for one cycle, held=0.
  - sync2=1 → PRESSED, cnt=0. There is no pulse.
- Outputs are registered.
  - pushed and released are high for exactly one clock per accepted event, never two consecutive cycles.
  - At most one pushed pulse occurs per accepted press, regardless of hold duration.
- Latency: count rising edges, with edge 1 being the first edge that samples btn_raw high.
  - pushed is high in the cycle after edge DEBOUNCE_CYCLES+2.
  - held rises on the same edge.
  - release latency is symmetric.
- Counter never exceeds DEBOUNCE_CYCLES. It saturates and never wraps.
- Simultaneous events: multiple channels may pulse in the same cycle. There is no arbitration or priority between channels.
- Reset during a press:
  - All state is cleared.
  - If the button is still held after rst drops, a new press is accepted after DEBOUNCE_CYCLES+2 edges and a new pushed pulse is issued.
  - No released pulse is generated for the press aborted by reset.
- Glitches shorter than DEBOUNCE_CYCLES samples on sync2 never produce pushed or released and never change held.

Test Plan (NUM_BTN=5, DEBOUNCE_CYCLES=4 unless noted):
- Reset check: assert rst for 2 cycles with btn_raw=5'b11111 → pushed, released and held all 0 during reset. After rst drops, all five pushed bits pulse together, 6 edges later, for exactly 1 cycle.
- Clean press: hold btn_raw[3] high for 20 cycles, then drop it.
  - pushed[3] is high only in the cycle after edge 6, and held[3] goes 1 on edge 6.
  - Counting edges from the fall, released[3] is high for one cycle after edge 6 and held[3] returns to 0.
  - Other bits stay 0.
- Bounce rejection: btn_raw[4] toggles 1,0,1,1,0,1,1,1,0 (one sample per cycle), then stays low → no pushed[4], held[4]=0 throughout. Then a steady high for 10 cycles → exactly one pushed[4].
- Release bounce: while held[3]=1, drop btn_raw[3] for 3 cycles, then restore it → no released[3], held[3] stays 1, no second pushed[3].
- Concurrent channels: btn_raw[3] and btn_raw[4] rise on the same edge → pushed[3] and pushed[4] pulse in the same cycle. A long hold of 50 cycles yields exactly one pulse each.
- Mid-press reset plus edge parameter: with btn_raw[0] held, assert rst while in PRESS_WAIT → no pulse, then re-accept after 6 edges. Rerun with DEBOUNCE_CYCLES=1 → pushed is high after edge 3.
